// File: rtl/pyrxacl_pingpong_ctrl.sv
// Two-bank (ping-pong) RX ACL payload buffer controller in front of one single-port SRAM.
// Optional PYRXACL_OVF_CNT_EN adds a saturating dropped-commit counter output (ovf_cnt).
module pyrxacl_pingpong_ctrl #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 8
) (
    input  logic          clk_6M,
    input  logic          rstz,
    input  logic          lnctrl_cs,
    input  logic          lnctrl_we,
    input  logic [AW-1:0] lnctrl_addr,
    input  logic [DW-1:0] lnctrl_din,
    input  logic          lnctrl_commit,
    input  logic [AW:0]   lnctrl_len,
    output logic          lnctrl_gnt,
    output logic          lnctrl_full,
    input  logic          bsm_cs,
    input  logic [AW-1:0] bsm_addr,
    input  logic          bsm_read_endp,
    output logic          bsm_rdy,
    output logic [AW:0]   bsm_len,
    output logic [DW-1:0] bsm_dout,
    output logic          bsm_dvld,
    input  logic          ovf_clr,
    output logic          ovf_sticky,
    output logic          sram_cs,
    output logic          sram_we,
    output logic [AW:0]   sram_a,
    output logic [DW-1:0] sram_din,
    input  logic [DW-1:0] sram_dout
`ifdef PYRXACL_OVF_CNT_EN
    ,
    output logic [7:0]    ovf_cnt
`endif
);

    localparam int unsigned LW         = AW + 1;
    localparam logic [AW:0] BANK_WORDS = {1'b1, {AW{1'b0}}};

    logic [1:0]         full_q, full_d;
    logic [1:0][LW-1:0] len_q, len_d;
    logic               wr_bank_q, wr_bank_d;
    logic               rd_bank_q, rd_bank_d;
    logic               ovf_q, ovf_d;
    logic               dvld_q, dvld_d;

    logic               bsm_acc;
    logic               release_ev;
    logic               drop;
    logic [LW-1:0]      commit_len;

    // Ownership flags and arbitration: bsm reads always win the SRAM port.
    assign lnctrl_full = full_q[wr_bank_q];
    assign bsm_rdy     = full_q[rd_bank_q];
    assign bsm_len     = bsm_rdy ? len_q[rd_bank_q] : '0;
    assign bsm_acc     = bsm_cs & bsm_rdy;
    assign lnctrl_gnt  = lnctrl_cs & ~lnctrl_full & ~bsm_acc;

    assign sram_cs     = bsm_acc | lnctrl_gnt;
    assign bsm_dout    = sram_dout;
    assign bsm_dvld    = dvld_q;
    assign ovf_sticky  = ovf_q;

    always_comb begin
        sram_a   = '0;
        sram_we  = 1'b0;
        sram_din = '0;
        if (bsm_acc) begin
            sram_a = {rd_bank_q, bsm_addr};
        end else if (lnctrl_gnt) begin
            sram_a   = {wr_bank_q, lnctrl_addr};
            sram_we  = lnctrl_we;
            sram_din = lnctrl_din;
        end
    end

    assign release_ev = bsm_read_endp & bsm_rdy;
    assign commit_len = (lnctrl_len > BANK_WORDS) ? BANK_WORDS : lnctrl_len;

    // Release is applied before commit so a full pair can accept a commit into the bank freed now.
    always_comb begin
        full_d    = full_q;
        len_d     = len_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        drop      = 1'b0;
        if (release_ev) begin
            full_d[rd_bank_q] = 1'b0;
            len_d[rd_bank_q]  = '0;
            rd_bank_d         = ~rd_bank_q;
        end
        if (lnctrl_commit && (lnctrl_len != '0)) begin
            if (!full_d[wr_bank_q]) begin
                full_d[wr_bank_q] = 1'b1;
                len_d[wr_bank_q]  = commit_len;
                wr_bank_d         = ~wr_bank_q;
            end else begin
                drop = 1'b1;
            end
        end
        ovf_d  = drop | (ovf_q & ~ovf_clr);
        dvld_d = bsm_acc;
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            full_q    <= '0;
            len_q     <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            ovf_q     <= 1'b0;
            dvld_q    <= 1'b0;
        end else begin
            full_q    <= full_d;
            len_q     <= len_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            ovf_q     <= ovf_d;
            dvld_q    <= dvld_d;
        end
    end

`ifdef PYRXACL_OVF_CNT_EN
    logic [7:0] ovf_cnt_q, ovf_cnt_d;

    // Clear and a same-cycle drop leave exactly one counted drop.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (ovf_clr) begin
            ovf_cnt_d = drop ? 8'd1 : 8'd0;
        end else if (drop && (ovf_cnt_q != 8'hFF)) begin
            ovf_cnt_d = ovf_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            ovf_cnt_q <= 8'd0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_pyrxacl_pingpong_ctrl.sv
// Scoreboarded bench for pyrxacl_pingpong_ctrl with a behavioural single-port SRAM.
module tb_pyrxacl_pingpong_ctrl;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 8;

    logic          clk_6M;
    logic          rstz;
    logic          lnctrl_cs, lnctrl_we, lnctrl_commit;
    logic [AW-1:0] lnctrl_addr;
    logic [DW-1:0] lnctrl_din;
    logic [AW:0]   lnctrl_len;
    logic          lnctrl_gnt, lnctrl_full;
    logic          bsm_cs, bsm_read_endp, bsm_rdy, bsm_dvld;
    logic [AW-1:0] bsm_addr;
    logic [AW:0]   bsm_len;
    logic [DW-1:0] bsm_dout;
    logic          ovf_clr, ovf_sticky;
    logic          sram_cs, sram_we;
    logic [AW:0]   sram_a;
    logic [DW-1:0] sram_din, sram_dout;
`ifdef PYRXACL_OVF_CNT_EN
    logic [7:0]    ovf_cnt;
`endif

    pyrxacl_pingpong_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk_6M        (clk_6M),
        .rstz          (rstz),
        .lnctrl_cs     (lnctrl_cs),
        .lnctrl_we     (lnctrl_we),
        .lnctrl_addr   (lnctrl_addr),
        .lnctrl_din    (lnctrl_din),
        .lnctrl_commit (lnctrl_commit),
        .lnctrl_len    (lnctrl_len),
        .lnctrl_gnt    (lnctrl_gnt),
        .lnctrl_full   (lnctrl_full),
        .bsm_cs        (bsm_cs),
        .bsm_addr      (bsm_addr),
        .bsm_read_endp (bsm_read_endp),
        .bsm_rdy       (bsm_rdy),
        .bsm_len       (bsm_len),
        .bsm_dout      (bsm_dout),
        .bsm_dvld      (bsm_dvld),
        .ovf_clr       (ovf_clr),
        .ovf_sticky    (ovf_sticky),
        .sram_cs       (sram_cs),
        .sram_we       (sram_we),
        .sram_a        (sram_a),
        .sram_din      (sram_din),
        .sram_dout     (sram_dout)
`ifdef PYRXACL_OVF_CNT_EN
        ,
        .ovf_cnt       (ovf_cnt)
`endif
    );

    initial clk_6M = 1'b0;
    always #5 clk_6M = ~clk_6M;

    // Behavioural SRAM with one-cycle read latency.
    logic [DW-1:0] mem [2**(AW+1)];
    always @(posedge clk_6M) begin
        if (sram_cs) begin
            if (sram_we) mem[sram_a] <= sram_din;
            else         sram_dout   <= mem[sram_a];
        end
    end

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q [$];
    logic [31:0] mon_exp;

    // Reference model of bank ownership.
    logic [1:0] full_m;
    logic [8:0] len_m [2];
    logic       wr_m, rd_m, ovf_m;
    logic [7:0] cnt_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    always @(negedge clk_6M) begin
        if (rstz && bsm_dvld) begin
            if (exp_q.size() == 0) begin
                check("dvld_unexpected", 32'(bsm_dvld), 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("bsm_dout", bsm_dout, mon_exp);
            end
        end
    end

    task automatic cyc();
        @(posedge clk_6M);
        @(negedge clk_6M);
    endtask

    task automatic model_reset();
        full_m   = 2'b00;
        len_m[0] = 9'd0;
        len_m[1] = 9'd0;
        wr_m     = 1'b0;
        rd_m     = 1'b0;
        ovf_m    = 1'b0;
        cnt_m    = 8'd0;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_full"}, 32'(lnctrl_full), 32'(full_m[wr_m]));
        check({tag, "_rdy"},  32'(bsm_rdy),     32'(full_m[rd_m]));
        check({tag, "_len"},  32'(bsm_len),     32'(full_m[rd_m] ? len_m[rd_m] : 9'd0));
        check({tag, "_ovf"},  32'(ovf_sticky),  32'(ovf_m));
`ifdef PYRXACL_OVF_CNT_EN
        check({tag, "_cnt"},  32'(ovf_cnt),     32'(cnt_m));
`endif
    endtask

    task automatic ctrl(input logic commit, input logic [8:0] clen, input logic endp, input logic clr);
        logic drop;
        lnctrl_commit = commit;
        lnctrl_len    = clen;
        bsm_read_endp = endp;
        ovf_clr       = clr;
        drop = 1'b0;
        if (endp && full_m[rd_m]) begin
            full_m[rd_m] = 1'b0;
            len_m[rd_m]  = 9'd0;
            rd_m         = ~rd_m;
        end
        if (commit && clen != 9'd0) begin
            if (!full_m[wr_m]) begin
                full_m[wr_m] = 1'b1;
                len_m[wr_m]  = (clen > 9'd256) ? 9'd256 : clen;
                wr_m         = ~wr_m;
            end else begin
                drop = 1'b1;
            end
        end
        ovf_m = drop | (ovf_m & ~clr);
        if (clr)                        cnt_m = drop ? 8'd1 : 8'd0;
        else if (drop && cnt_m != 8'hFF) cnt_m = cnt_m + 8'd1;
        cyc();
        lnctrl_commit = 1'b0;
        lnctrl_len    = '0;
        bsm_read_endp = 1'b0;
        ovf_clr       = 1'b0;
    endtask

    task automatic lwrite(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        lnctrl_cs   = 1'b1;
        lnctrl_we   = 1'b1;
        lnctrl_addr = addr;
        lnctrl_din  = data;
        #1;
        check("wr_gnt",    32'(lnctrl_gnt), 32'd1);
        check("wr_sram_a", 32'(sram_a),     32'({wr_m, addr}));
        check("wr_we",     32'(sram_we),    32'd1);
        check("wr_din",    sram_din,        data);
        cyc();
        lnctrl_cs = 1'b0;
        lnctrl_we = 1'b0;
    endtask

    task automatic bread(input logic [AW-1:0] addr, input logic [DW-1:0] expd);
        bsm_cs   = 1'b1;
        bsm_addr = addr;
        #1;
        check("rd_sram_a",  32'(sram_a),  32'({rd_m, addr}));
        check("rd_sram_cs", 32'(sram_cs), 32'd1);
        check("rd_sram_we", 32'(sram_we), 32'd0);
        exp_q.push_back(expd);
        cyc();
        bsm_cs = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstz = 1'b0;
        lnctrl_cs = 1'b0; lnctrl_we = 1'b0; lnctrl_commit = 1'b0;
        lnctrl_addr = '0; lnctrl_din = '0; lnctrl_len = '0;
        bsm_cs = 1'b0; bsm_addr = '0; bsm_read_endp = 1'b0; ovf_clr = 1'b0;
        model_reset();
        for (int i = 0; i < 2**(AW+1); i++) mem[i] = '0;
        cyc(); cyc();
        check("rst_gnt",     32'(lnctrl_gnt), 32'd0);
        check("rst_sram_cs", 32'(sram_cs),    32'd0);
        check("rst_sram_we", 32'(sram_we),    32'd0);
        check("rst_dvld",    32'(bsm_dvld),   32'd0);
        check_state("rst");
        rstz = 1'b1;
        cyc();

        // Basic fill / commit / read.
        for (int i = 0; i < 4; i++) lwrite(AW'(i), 32'hA0 + 32'(i));
        ctrl(1'b1, 9'd4, 1'b0, 1'b0);
        check_state("t1");
        check("t1_len4", 32'(bsm_len), 32'd4);
        bread(8'd2, 32'hA2);
        check("t1_dvld", 32'(bsm_dvld), 32'd1);
        cyc();
        check("t1_dvld_off", 32'(bsm_dvld), 32'd0);
        ctrl(1'b0, 9'd0, 1'b1, 1'b0);
        check_state("t1_rel");

        // Overflow on a third commit, clear priority.
        ctrl(1'b1, 9'd5, 1'b0, 1'b0);
        ctrl(1'b1, 9'd7, 1'b0, 1'b0);
        check("t2_full", 32'(lnctrl_full), 32'd1);
        ctrl(1'b1, 9'd3, 1'b0, 1'b0);
        check_state("t2_drop");
        check("t2_ovf", 32'(ovf_sticky), 32'd1);
        check("t2_len5", 32'(bsm_len), 32'd5);
        ctrl(1'b1, 9'd3, 1'b0, 1'b1);
        check_state("t2_dropclr");
        ctrl(1'b0, 9'd0, 1'b0, 1'b1);
        check_state("t2_clr");
        ctrl(1'b0, 9'd0, 1'b1, 1'b0);
        check("t2_len7", 32'(bsm_len), 32'd7);
        ctrl(1'b0, 9'd0, 1'b1, 1'b0);
        check_state("t2_empty");

        // Arbitration: bsm wins, lnctrl holds its request and lands next cycle.
        lwrite(8'd5, 32'h55);
        ctrl(1'b1, 9'd1, 1'b0, 1'b0);
        bsm_cs = 1'b1; bsm_addr = 8'd5;
        lnctrl_cs = 1'b1; lnctrl_we = 1'b1; lnctrl_addr = 8'd9; lnctrl_din = 32'h99;
        #1;
        check("t3_gnt_blk", 32'(lnctrl_gnt), 32'd0);
        check("t3_we_blk",  32'(sram_we),    32'd0);
        check("t3_a_rd",    32'(sram_a),     32'({rd_m, 8'd5}));
        check("t3_din_rd",  sram_din,        32'd0);
        exp_q.push_back(32'h55);
        cyc();
        bsm_cs = 1'b0;
        #1;
        check("t3_gnt", 32'(lnctrl_gnt), 32'd1);
        check("t3_we",  32'(sram_we),    32'd1);
        check("t3_a_wr", 32'(sram_a),    32'({wr_m, 8'd9}));
        cyc();
        lnctrl_cs = 1'b0; lnctrl_we = 1'b0;
        ctrl(1'b1, 9'd10, 1'b0, 1'b0);
        ctrl(1'b0, 9'd0, 1'b1, 1'b0);
        bread(8'd9, 32'h99);
        ctrl(1'b0, 9'd0, 1'b1, 1'b0);
        check_state("t3_end");

        // Same-cycle commit and release with both banks full.
        ctrl(1'b1, 9'd2, 1'b0, 1'b0);
        ctrl(1'b1, 9'd3, 1'b0, 1'b0);
        ctrl(1'b1, 9'd6, 1'b1, 1'b0);
        check_state("t4_swap");
        check("t4_ovf", 32'(ovf_sticky), 32'd0);
        check("t4_full", 32'(lnctrl_full), 32'd1);
        check("t4_len3", 32'(bsm_len), 32'd3);
        bread(8'd2, 32'hA2);
        ctrl(1'b0, 9'd0, 1'b1, 1'b0);
        check("t4_len6", 32'(bsm_len), 32'd6);
        lwrite(8'd3, 32'h33);
        ctrl(1'b0, 9'd0, 1'b1, 1'b0);
        check_state("t4_end");

        // Boundaries: zero-length commit, release when empty, read when not ready, oversize length.
        ctrl(1'b1, 9'd0, 1'b0, 1'b0);
        check_state("t5_len0");
        ctrl(1'b0, 9'd0, 1'b1, 1'b0);
        check_state("t5_endp");
        bsm_cs = 1'b1; bsm_addr = 8'd1;
        #1;
        check("t5_nrdy_cs", 32'(sram_cs), 32'd0);
        cyc();
        bsm_cs = 1'b0;
        cyc();
        check("t5_nrdy_dvld", 32'(bsm_dvld), 32'd0);
        ctrl(1'b1, 9'd257, 1'b0, 1'b0);
        check("t5_len_sat", 32'(bsm_len), 32'd256);
        ctrl(1'b1, 9'd9, 1'b0, 1'b0);
        ctrl(1'b1, 9'd4, 1'b0, 1'b0);
        check_state("t5_full");

        // Asynchronous reset while both banks are full and a read is in flight.
        bread(8'd0, 32'hA0);
        #2;
        rstz = 1'b0;
        #1;
        model_reset();
        check("t6_dvld", 32'(bsm_dvld), 32'd0);
        check("t6_cs",   32'(sram_cs),  32'd0);
        check_state("t6_rst");
        cyc();
        rstz = 1'b1;
        cyc();

        // Long run of drops to saturate the overflow counter.
        ctrl(1'b1, 9'd1, 1'b0, 1'b0);
        ctrl(1'b1, 9'd1, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) ctrl(1'b1, 9'd1, 1'b0, 1'b0);
        check_state("t6_sat");
`ifdef PYRXACL_OVF_CNT_EN
        check("t6_cnt255", 32'(ovf_cnt), 32'd255);
`endif
        cyc();
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
